// File: rtl/versioned_store.sv
// Versioned multi-slot store: per-address (version, data) slots with overwrite/evict-oldest
// writes, whole-address invalidate, and a two-stage back-pressured snapshot read pipeline.
module versioned_store #(
    parameter int DATA_WIDTH    = 32,
    parameter int VERSION_WIDTH = 4,
    parameter int VERSION_NUM   = 4,
    parameter int DEPTH         = 8,
    parameter int ADDR_WIDTH    = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    input  logic [ADDR_WIDTH-1:0]    wr_addr,
    input  logic [VERSION_WIDTH-1:0] wr_version,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     inv_valid,
    input  logic [ADDR_WIDTH-1:0]    inv_addr,
    input  logic                     rd_req_valid,
    output logic                     rd_req_ready,
    input  logic [ADDR_WIDTH-1:0]    rd_addr,
    input  logic [VERSION_WIDTH-1:0] rd_version,
    output logic                     rd_resp_valid,
    input  logic                     rd_resp_ready,
    output logic                     rd_hit,
    output logic [VERSION_WIDTH-1:0] rd_found_version,
    output logic [DATA_WIDTH-1:0]    rd_data
);
    localparam int SLOT_W = (VERSION_NUM > 1) ? $clog2(VERSION_NUM) : 1;

    logic                     slotValid [DEPTH][VERSION_NUM];
    logic [VERSION_WIDTH-1:0] slotVer   [DEPTH][VERSION_NUM];
    logic [DATA_WIDTH-1:0]    slotData  [DEPTH][VERSION_NUM];

    logic [VERSION_NUM-1:0]   wrLive;
    logic                     matchFound, freeFound, oldFound;
    logic [SLOT_W-1:0]        matchIdx, freeIdx, oldIdx, wrSlot;
    logic [VERSION_WIDTH-1:0] oldVer;

    // A same-address invalidate is folded in first, so the write lands in slot 0 of an empty entry.
    always_comb begin
        wrLive     = '0;
        matchFound = 1'b0;
        freeFound  = 1'b0;
        oldFound   = 1'b0;
        matchIdx   = '0;
        freeIdx    = '0;
        oldIdx     = '0;
        oldVer     = '0;
        for (int unsigned i = 0; i < VERSION_NUM; i++) begin
            wrLive[i] = slotValid[wr_addr][i] && !(inv_valid && (inv_addr == wr_addr));
            if (wrLive[i] && (slotVer[wr_addr][i] == wr_version) && !matchFound) begin
                matchFound = 1'b1;
                matchIdx   = SLOT_W'(i);
            end
            if (!wrLive[i] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = SLOT_W'(i);
            end
            if (wrLive[i] && (!oldFound || (slotVer[wr_addr][i] < oldVer))) begin
                oldFound = 1'b1;
                oldIdx   = SLOT_W'(i);
                oldVer   = slotVer[wr_addr][i];
            end
        end
        wrSlot = matchFound ? matchIdx : (freeFound ? freeIdx : oldIdx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned a = 0; a < DEPTH; a++)
                for (int unsigned s = 0; s < VERSION_NUM; s++)
                    slotValid[a][s] <= 1'b0;
        end else begin
            if (inv_valid)
                for (int unsigned s = 0; s < VERSION_NUM; s++)
                    slotValid[inv_addr][s] <= 1'b0;
            if (wr_valid)
                slotValid[wr_addr][wrSlot] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_valid) begin
            slotVer[wr_addr][wrSlot]  <= wr_version;
            slotData[wr_addr][wrSlot] <= wr_data;
        end
    end

    logic                     s1Valid;
    logic [VERSION_WIDTH-1:0] s1Version;
    logic                     s1SlotValid [VERSION_NUM];
    logic [VERSION_WIDTH-1:0] s1SlotVer   [VERSION_NUM];
    logic [DATA_WIDTH-1:0]    s1SlotData  [VERSION_NUM];

    logic                     s2Valid, s2Hit;
    logic [VERSION_WIDTH-1:0] s2Ver;
    logic [DATA_WIDTH-1:0]    s2Data;

    logic                     selHit;
    logic [VERSION_WIDTH-1:0] selVer;
    logic [DATA_WIDTH-1:0]    selData;
    logic                     s2Advance, reqFire;

    always_comb begin
        selHit  = 1'b0;
        selVer  = '0;
        selData = '0;
        for (int unsigned i = 0; i < VERSION_NUM; i++) begin
            if (s1SlotValid[i] && (s1SlotVer[i] <= s1Version) && (!selHit || (s1SlotVer[i] > selVer))) begin
                selHit  = 1'b1;
                selVer  = s1SlotVer[i];
                selData = s1SlotData[i];
            end
        end
    end

    assign s2Advance    = !s2Valid || rd_resp_ready;
    assign rd_req_ready = !s1Valid || s2Advance;
    assign reqFire      = rd_req_valid && rd_req_ready;

    // S1 samples the slots before this edge's write/invalidate lands, giving snapshot semantics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid   <= 1'b0;
            s1Version <= '0;
            for (int unsigned s = 0; s < VERSION_NUM; s++) begin
                s1SlotValid[s] <= 1'b0;
                s1SlotVer[s]   <= '0;
                s1SlotData[s]  <= '0;
            end
            s2Valid <= 1'b0;
            s2Hit   <= 1'b0;
            s2Ver   <= '0;
            s2Data  <= '0;
        end else begin
            if (s2Advance) begin
                s2Valid <= s1Valid;
                if (s1Valid) begin
                    s2Hit  <= selHit;
                    s2Ver  <= selVer;
                    s2Data <= selData;
                end
            end
            if (reqFire) begin
                s1Valid   <= 1'b1;
                s1Version <= rd_version;
                for (int unsigned s = 0; s < VERSION_NUM; s++) begin
                    s1SlotValid[s] <= slotValid[rd_addr][s];
                    s1SlotVer[s]   <= slotVer[rd_addr][s];
                    s1SlotData[s]  <= slotData[rd_addr][s];
                end
            end else if (s2Advance) begin
                s1Valid <= 1'b0;
            end
        end
    end

    assign rd_resp_valid    = s2Valid;
    assign rd_hit           = s2Hit;
    assign rd_found_version = s2Ver;
    assign rd_data          = s2Data;

endmodule

// File: tb/tb_versioned_store.sv
// Bench for versioned_store: directed vector table, hazard/back-pressure/reset sequences,
// and randomized traffic against a version-indexed reference model.
module tb_versioned_store;
    localparam int DW = 32;
    localparam int VW = 4;
    localparam int VN = 4;
    localparam int DP = 8;
    localparam int AW = 3;
    localparam int OP_WR = 0;
    localparam int OP_RD = 1;
    localparam int OP_IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, inv_valid, rd_req_valid, rd_resp_ready;
    logic [AW-1:0] wr_addr, inv_addr, rd_addr;
    logic [VW-1:0] wr_version, rd_version, rd_found_version;
    logic [DW-1:0] wr_data, rd_data;
    logic          rd_req_ready, rd_resp_valid, rd_hit;

    versioned_store #(.DATA_WIDTH(DW), .VERSION_WIDTH(VW), .VERSION_NUM(VN), .DEPTH(DP), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_version(wr_version), .wr_data(wr_data),
        .inv_valid(inv_valid), .inv_addr(inv_addr),
        .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_addr(rd_addr), .rd_version(rd_version),
        .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
        .rd_hit(rd_hit), .rd_found_version(rd_found_version), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            op;
        int            addr;
        int            ver;
        logic [DW-1:0] data;
        int            invAddr;
        logic          eh;
        int            ev;
        logic [DW-1:0] ed;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Model keyed by version value: presence bit plus payload per (address, version).
    bit            mPres [DP][16];
    logic [DW-1:0] mDat  [DP][16];
    logic [VW+DW:0] expQ [$];
    vec_t vecs [$];
    int bpV [4] = '{6, 15, 3, 2};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void mClear();
        for (int a = 0; a < DP; a++)
            for (int v = 0; v < 16; v++) begin
                mPres[a][v] = 1'b0;
                mDat[a][v]  = '0;
            end
    endfunction

    function automatic void mInv(int a);
        for (int v = 0; v < 16; v++) mPres[a][v] = 1'b0;
    endfunction

    function automatic void mWrite(int a, int v, logic [DW-1:0] d);
        int cnt = 0;
        if (!mPres[a][v]) begin
            for (int i = 0; i < 16; i++) if (mPres[a][i]) cnt++;
            if (cnt >= VN) begin
                for (int i = 0; i < 16; i++)
                    if (mPres[a][i]) begin
                        mPres[a][i] = 1'b0;
                        break;
                    end
            end
        end
        mPres[a][v] = 1'b1;
        mDat[a][v]  = d;
    endfunction

    function automatic logic [VW+DW:0] mRead(int a, int v);
        for (int i = v; i >= 0; i--)
            if (mPres[a][i]) return {1'b1, VW'(i), mDat[a][i]};
        return '0;
    endfunction

    // Entered and left at posedge+1; inputs are already driven for this cycle.
    task automatic cycleStep(output bit accepted, output bit responded);
        logic [VW+DW:0] e;
        accepted  = 1'b0;
        responded = 1'b0;
        #1;
        check("req_ready", rd_req_ready, (expQ.size() < 2) || rd_resp_ready);
        if (rd_resp_valid && rd_resp_ready) begin
            responded = 1'b1;
            if (expQ.size() == 0) check("spurious_resp", rd_resp_valid, 0);
            else begin
                e = expQ.pop_front();
                check("resp", {rd_hit, rd_found_version, rd_data}, e);
            end
        end
        if (rd_req_valid && rd_req_ready) begin
            accepted = 1'b1;
            expQ.push_back(mRead(int'(rd_addr), int'(rd_version)));
        end
        if (inv_valid) mInv(int'(inv_addr));
        if (wr_valid) mWrite(int'(wr_addr), int'(wr_version), wr_data);
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input int a, input int v, input logic [DW-1:0] d, input bit invOn, input int ia);
        wr_valid   = 1'b1;
        wr_addr    = AW'(a);
        wr_version = VW'(v);
        wr_data    = d;
        inv_valid  = invOn;
        inv_addr   = AW'(ia);
        @(posedge clk);
        if (invOn) mInv(ia);
        mWrite(a, v, d);
        #1;
        wr_valid  = 1'b0;
        inv_valid = 1'b0;
    endtask

    task automatic doRead(input int a, input int v, input logic [VW+DW:0] exp, input string tag);
        rd_req_valid  = 1'b1;
        rd_addr       = AW'(a);
        rd_version    = VW'(v);
        rd_resp_ready = 1'b1;
        #1;
        check({tag, "_ready"}, rd_req_ready, 1);
        @(posedge clk);
        #1;
        rd_req_valid = 1'b0;
        check({tag, "_lat1"}, rd_resp_valid, 0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, rd_resp_valid, 1);
        check(tag, {rd_hit, rd_found_version, rd_data}, exp);
    endtask

    initial begin
        bit acc, rsp;
        int accN, nResp, first, last;

        rst = 1'b1;
        wr_valid = 1'b0; inv_valid = 1'b0; rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
        wr_addr = '0; inv_addr = '0; rd_addr = '0; wr_version = '0; rd_version = '0; wr_data = '0;
        mClear();
        #2;
        check("rst_resp_valid", rd_resp_valid, 0);
        check("rst_hit", rd_hit, 0);
        check("rst_ver", rd_found_version, 0);
        check("rst_data", rd_data, 0);
        check("rst_req_ready", rd_req_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Write lands on the same edge that accepts the read: read must not see it.
        wr_valid = 1'b1; wr_addr = 3'd0; wr_version = 4'd1; wr_data = 32'h11;
        rd_req_valid = 1'b1; rd_addr = 3'd0; rd_version = 4'd15;
        @(posedge clk);
        #1;
        mWrite(0, 1, 32'h11);
        wr_valid = 1'b0; rd_req_valid = 1'b0;
        check("hazard_lat1", rd_resp_valid, 0);
        @(posedge clk);
        #1;
        check("hazard_valid", rd_resp_valid, 1);
        check("hazard_miss", {rd_hit, rd_found_version, rd_data}, 0);
        doRead(0, 15, {1'b1, 4'd1, 32'h11}, "hazard_after");

        vecs.push_back('{OP_WR, 2, 3, 32'hA, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 2, 7, 32'hB, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 2, 5, 32'hC, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 2, 6, 32'h0, 0, 1'b1, 5, 32'hC});
        vecs.push_back('{OP_RD, 2, 15, 32'h0, 0, 1'b1, 7, 32'hB});
        vecs.push_back('{OP_RD, 2, 2, 32'h0, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 5, 15, 32'h0, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 2, 3, 32'h0, 0, 1'b1, 3, 32'hA});
        vecs.push_back('{OP_WR, 1, 4, 32'h40, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 1, 9, 32'h90, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 1, 2, 32'h20, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 1, 6, 32'h60, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_WR, 1, 8, 32'h55, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 1, 3, 32'h0, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 1, 8, 32'h0, 0, 1'b1, 8, 32'h55});
        vecs.push_back('{OP_WR, 1, 9, 32'h77, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 1, 15, 32'h0, 0, 1'b1, 9, 32'h77});
        vecs.push_back('{OP_RD, 1, 5, 32'h0, 0, 1'b1, 4, 32'h40});
        vecs.push_back('{OP_RD, 1, 7, 32'h0, 0, 1'b1, 6, 32'h60});
        vecs.push_back('{OP_IW, 0, 4, 32'h44, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 0, 15, 32'h0, 0, 1'b1, 4, 32'h44});
        vecs.push_back('{OP_RD, 0, 4, 32'h0, 0, 1'b1, 4, 32'h44});
        vecs.push_back('{OP_RD, 0, 3, 32'h0, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_IW, 3, 2, 32'h33, 1, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 1, 15, 32'h0, 0, 1'b0, 0, 32'h0});
        vecs.push_back('{OP_RD, 3, 2, 32'h0, 0, 1'b1, 2, 32'h33});

        foreach (vecs[k]) begin
            vec_t t;
            t = vecs[k];
            if (t.op == OP_RD) doRead(t.addr, t.ver, {t.eh, VW'(t.ev), t.ed}, $sformatf("vec%0d", k));
            else doWrite(t.addr, t.ver, t.data, t.op == OP_IW, t.invAddr);
        end
        @(posedge clk);
        @(posedge clk);
        #1;

        // Back-pressure: four reads of addr 2 against a stalled consumer, with a write mid-stall.
        accN = 0;
        rd_resp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            rd_req_valid = 1'b1;
            rd_addr      = 3'd2;
            rd_version   = VW'(bpV[accN]);
            wr_valid     = (c == 2);
            wr_addr      = 3'd2; wr_version = 4'd6; wr_data = 32'hDD;
            cycleStep(acc, rsp);
            if (acc) accN++;
        end
        wr_valid = 1'b0;
        check("bp_accepted", accN, 2);
        check("bp_req_ready", rd_req_ready, 0);
        check("bp_held_valid", rd_resp_valid, 1);
        check("bp_held", {rd_hit, rd_found_version, rd_data}, {1'b1, 4'd5, 32'hC});
        rd_resp_ready = 1'b1;
        nResp = 0; first = 0; last = 0;
        for (int c = 0; c < 12 && nResp < 4; c++) begin
            rd_req_valid = (accN < 4);
            rd_version   = VW'(bpV[accN < 4 ? accN : 3]);
            cycleStep(acc, rsp);
            if (acc) accN++;
            if (rsp) begin
                if (nResp == 0) first = c;
                last = c;
                nResp++;
            end
        end
        rd_req_valid = 1'b0;
        check("bp_resp_count", nResp, 4);
        check("bp_resp_spacing", last - first, 3);

        for (int c = 0; c < 300; c++) begin
            wr_valid      = ($urandom_range(0, 9) < 6);
            wr_addr       = AW'($urandom_range(0, DP - 1));
            wr_version    = VW'($urandom_range(0, 15));
            wr_data       = $urandom;
            inv_valid     = ($urandom_range(0, 15) == 0);
            inv_addr      = AW'($urandom_range(0, DP - 1));
            rd_req_valid  = ($urandom_range(0, 9) < 6);
            rd_addr       = AW'($urandom_range(0, DP - 1));
            rd_version    = VW'($urandom_range(0, 15));
            rd_resp_ready = ($urandom_range(0, 9) < 7);
            cycleStep(acc, rsp);
        end
        wr_valid = 1'b0; inv_valid = 1'b0; rd_req_valid = 1'b0; rd_resp_ready = 1'b1;
        for (int c = 0; c < 10 && expQ.size() > 0; c++) cycleStep(acc, rsp);
        check("drain_pending", expQ.size(), 0);

        // Reset asserted between edges with two reads in flight.
        rd_resp_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rd_req_valid = 1'b1;
            rd_addr      = AW'(c + 2);
            rd_version   = 4'd15;
            cycleStep(acc, rsp);
        end
        rd_req_valid = 1'b0;
        check("pre_rst_valid", rd_resp_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_resp_valid", rd_resp_valid, 0);
        check("arst_hit", rd_hit, 0);
        check("arst_ver", rd_found_version, 0);
        check("arst_data", rd_data, 0);
        check("arst_req_ready", rd_req_ready, 1);
        expQ.delete();
        mClear();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_resp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("post_rst_no_resp", rd_resp_valid, 0);
            @(posedge clk);
            #1;
        end
        for (int a = 0; a < DP; a++) doRead(a, 15, '0, $sformatf("post_rst_a%0d", a));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
